apb_master_ctrl: RTL
====================

# apb_master_ctrl

APB master controller that sits between the RV32I multi-cycle core's data port (`dAddr`/`wData`/`rData`/`dWe`/`apb_req`/`apb_ready`) and a bank of APB slaves. It latches each core request, sequences the APB SETUP/ACCESS phases, and decodes the address to a one-hot `psel`. It returns the selected slave's `prdata`/`pready` to the core, and terminates unmapped or hung transfers with an error.

## Interface
- NUM_SLAVES, 4: number of APB slave slots (1..8).
- BASE_ADDR, 32'h1000_0000: start of the mapped window.
- SLOT_LOG2, 12: log2 of bytes per slave slot (4 KiB).
- TIMEOUT, 255: maximum ACCESS cycles before forced termination (8-bit).
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- req  in  1  core transfer request (core `apb_req`), held until `ready`.
- we  in  1  write enable (core `dWe`).
- addr  in  32  byte address (core `dAddr`).
- wdata  in  32  write data (core `wData`).
- rdata  out  32  read data to core (core `rData`).
- ready  out  1  transfer complete (core `apb_ready`), one-cycle pulse.
- err  out  1  completing transfer was unmapped or timed out; valid only with `ready`.
- paddr  out  32  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  32  APB write data.
- penable  out  1  APB enable.
- psel  out  NUM_SLAVES  one-hot slave select.
- prdata  in  NUM_SLAVES*32  packed slave read data; slot i = [32*i+31:32*i].
- pready  in  NUM_SLAVES  per-slave ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS, ERROR.
- IDLE: if `req`=1, latch `addr`, `we`, `wdata` and the decoded slot.
  - Mapped address: go to SETUP.
  - Unmapped address: go to ERROR.
- Decode: mapped iff `addr - BASE_ADDR < NUM_SLAVES << SLOT_LOG2` (unsigned 32-bit; addresses below BASE wrap to large values and are unmapped). Slot index = `(addr - BASE_ADDR) >> SLOT_LOG2`.
- SETUP: `psel[slot]`=1, `penable`=0. Always go to ACCESS next cycle. Clear the timeout counter.
- ACCESS: `psel[slot]`=1, `penable`=1.
  - If `pready[slot]`: `ready`=1, `rdata`=`prdata[slot]`, `err`=0, go to IDLE.
  - Else if counter==TIMEOUT: `ready`=1, `rdata`=0, `err`=1, go to IDLE.
  - Else increment the counter.
- ERROR: `ready`=1, `err`=1, `rdata`=0, no `psel`. Go to IDLE.
- `paddr`/`pwrite`/`pwdata` are driven from latched registers and stay stable from SETUP through the end of ACCESS.
- `pready`/`prdata` of non-selected slots are ignored.
- `rdata`=0 whenever `ready`=0.
- After completion the FSM always returns to IDLE; a new transfer needs a fresh `req` sampled in IDLE. The core drops `req` on the same edge it sees `ready`, so there is no double issue.
- `req` deasserting mid-transfer is ignored: the APB transfer runs to completion.

## Timing
- Reset values: state IDLE; `psel`=0, `penable`=0, `paddr`=0, `pwrite`=0, `pwdata`=0, `ready`=0, `err`=0, `rdata`=0; counter 0.
- Reset asserted in any state returns the FSM to IDLE immediately and drops `psel`/`penable` asynchronously.
- Mapped transfer with zero wait states: `req` sampled at edge 0, SETUP in cycle 1, ACCESS plus `ready` in cycle 2. Latency is 2 cycles from first `req` cycle to `ready`.
- Each slave wait state adds 1 cycle.
- Unmapped transfer: `ready` in cycle 1.
- Timeout: `ready` in the ACCESS cycle where counter==TIMEOUT, i.e. TIMEOUT+1 ACCESS cycles total.
- `ready`/`rdata`/`err` are combinational from state and the selected `pready`/`prdata`, so the core registers `rdata` on the same edge it sees `ready`.
- `penable`/`psel` are decoded from registered state, so they are glitch-free.
- There is no combinational path from `req` to any APB output.

## Structure
- Package `apb_pkg` holds the `apb_state_e` enum (IDLE, SETUP, ACCESS, ERROR) and default map constants (BASE, SLOT_LOG2).
- Sub-module `apb_addr_decoder`, purely combinational: takes `addr`, outputs `hit` and a one-hot `sel[NUM_SLAVES]`. Parameterised identically to the top.
- The top contains the FSM, the latch registers, the 8-bit timeout counter, and the `prdata`/`pready` return mux.

## Test plan
- Read, slot 0, zero-wait: `addr`=32'h1000_0010, `we`=0, slave 0 `pready`=1, `prdata`=32'hCAFE_0001.
  - Expect `psel`=4'b0001 in cycles 1-2, `penable` in cycle 2 only.
  - Expect `ready`=1 and `rdata`=32'hCAFE_0001 in cycle 2, `err`=0.
- Write, slot 2, 3 wait states: `addr`=32'h1000_2004, `wdata`=32'h1234_5678, `pready[2]` rises after 3 ACCESS cycles.
  - Expect `paddr`/`pwdata`/`pwrite`=1 stable over 5 cycles.
  - Expect `ready` in cycle 5.
- Unmapped addresses: `addr`=32'h2000_0000, then 32'h0FFF_FFFC.
  - Expect `psel`=0 throughout.
  - Expect `ready`=1, `err`=1, `rdata`=0 in cycle 1 for each.
- Timeout, TIMEOUT=255: slave 1 never asserts `pready`.
  - Expect `ready`/`err` in the 256th ACCESS cycle.
  - Expect `psel`/`penable`=0 on the following cycle.
- Reset mid-ACCESS: assert `reset` during wait states.
  - Expect all outputs 0 immediately and state IDLE.
  - A subsequent read to slot 3 completes normally.
- Core integration: run `sw` then `lw` to 32'h1000_1000 on the RV32I core with a RAM slave.
  - Expect the register file to receive the stored value.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and default address-map constants for the APB master
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } apb_state_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
    localparam int          DEF_SLOT_LOG2 = 12;
    localparam int          DEF_TIMEOUT   = 255;

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps a byte address onto a one-hot slave select inside the APB window
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          SLOT_LOG2  = DEF_SLOT_LOG2
) (
    input  logic [31:0]           addr,
    output logic                  hit,
    output logic [NUM_SLAVES-1:0] sel
);

    // Window size kept one bit wider so it cannot overflow for 8 slots of large size
    localparam logic [32:0] WINDOW = 33'(NUM_SLAVES) << SLOT_LOG2;

    logic [31:0] offset;
    logic [31:0] slot;

    // Addresses below the base wrap to huge offsets and fall outside the window
    always_comb begin
        offset = addr - BASE_ADDR;
        slot   = offset >> SLOT_LOG2;
        hit    = {1'b0, offset} < WINDOW;
        sel    = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            sel[i] = hit && (slot == 32'(i));
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: bridges the core data port to a bank of APB slaves with decode and timeout
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          SLOT_LOG2  = DEF_SLOT_LOG2,
    parameter int          TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     we,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     ready,
    output logic                     err,
    output logic [31:0]              paddr,
    output logic                     pwrite,
    output logic [31:0]              pwdata,
    output logic                     penable,
    output logic [NUM_SLAVES-1:0]    psel,
    input  logic [NUM_SLAVES*32-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]    pready
);

    apb_state_e            state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [7:0]            cnt_q, cnt_d;

    logic                  dec_hit;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  slv_ready;
    logic [31:0]           slv_rdata;
    logic                  timed_out;

    apb_addr_decoder #(
        .NUM_SLAVES(NUM_SLAVES),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_LOG2 (SLOT_LOG2)
    ) u_dec (
        .addr(addr),
        .hit (dec_hit),
        .sel (dec_sel)
    );

    assign timed_out = cnt_q == 8'(TIMEOUT);
    assign paddr     = addr_q;
    assign pwrite    = we_q;
    assign pwdata    = wdata_q;

    // Return mux: AND-OR over the latched one-hot select so unselected slaves are ignored
    always_comb begin
        slv_ready = |(pready & sel_q);
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            slv_rdata = slv_rdata | (prdata[32*i +: 32] & {32{sel_q[i]}});
    end

    // State, request latches and wait counter; reset clears everything asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: capture request in IDLE, count ACCESS wait cycles until ready or timeout
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = dec_hit ? SETUP : ERROR;
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = we;
                    sel_d   = dec_sel;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (slv_ready || timed_out)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: APB strobes from registered state only; core response is combinational
    always_comb begin
        psel    = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
        penable = state_q == ACCESS;
        ready   = (state_q == ERROR) || (state_q == ACCESS && (slv_ready || timed_out));
        err     = (state_q == ERROR) || (state_q == ACCESS && !slv_ready && timed_out);
        rdata   = (state_q == ACCESS && slv_ready) ? slv_rdata : '0;
    end

endmodule
